// File: rtl/cache_write_buffer_if.sv
// Request/grant/rvalid bus shared by the cache side and the memory side.
// The requester is the master; the responder is the slave.
interface cache_write_buffer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        req;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        error;

  modport master (output addr, wdata, we, req, be, input gnt, rvalid, rdata, error);
  modport slave  (input addr, wdata, we, req, be, output gnt, rvalid, rdata, error);
endinterface

// File: rtl/cache_write_buffer.sv
// Posted-write buffer: acknowledges cache stores in one cycle, drains them to
// memory in the background and passes reads through unless they alias a
// buffered store (no forwarding, the read simply waits for the drain).
module cache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  cache_write_buffer_if.slave         up,
  cache_write_buffer_if.master        mem,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        drain_error_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, DRAIN_REQ, DRAIN_WAIT, READ_REQ, READ_WAIT} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q;
  logic             read_pending_q;
  logic [31:0]      rd_addr_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             error_q;
  logic             drain_err_q;
  logic             hazard, wr_gnt, rd_gnt, push, pop;
  entry_t           head_e;

  assign head_e  = fifo_q[head_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign drain_error_o = drain_err_q;

  // Word-address match against every occupied slot, including the head being drained
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) &&
          (fifo_q[head_q + PTR_W'(i)].addr[31:2] == up.addr[31:2]))
        hazard = 1'b1;
    end
  end

  // full_o is the registered count, so a pop this cycle never frees a slot early
  assign wr_gnt  = up.req &  up.we & ~full_o & ~read_pending_q;
  assign rd_gnt  = up.req & ~up.we & (state_q == IDLE) & ~hazard & ~full_o & ~read_pending_q;
  assign up.gnt  = wr_gnt | rd_gnt;
  assign push    = wr_gnt;
  assign pop     = (state_q == DRAIN_WAIT) & mem.rvalid;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  assign up.rvalid = rvalid_q;
  assign up.rdata  = rdata_q;
  assign up.error  = error_q;

  // Memory bus decoded straight from the state register; head is stable while draining
  always_comb begin
    mem.req   = (state_q == DRAIN_REQ) || (state_q == READ_REQ);
    mem.we    = (state_q == DRAIN_REQ);
    mem.addr  = '0;
    mem.wdata = '0;
    mem.be    = '0;
    if (state_q == DRAIN_REQ) begin
      mem.addr  = head_e.addr;
      mem.wdata = head_e.wdata;
      mem.be    = head_e.be;
    end else if (state_q == READ_REQ) begin
      mem.addr  = rd_addr_q;
      mem.be    = 4'b1111;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= '{addr: up.addr, wdata: up.wdata, be: up.be};
  end

  // Circular pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Sequencer: reads beat drains in IDLE; one memory transaction at a time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      read_pending_q <= 1'b0;
      rd_addr_q      <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      error_q        <= 1'b0;
      drain_err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (wr_gnt) begin
        rvalid_q <= 1'b1;
        rdata_q  <= '0;
        error_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rd_gnt) begin
            state_q        <= READ_REQ;
            rd_addr_q      <= up.addr;
            read_pending_q <= 1'b1;
          end else if (count_q != '0) begin
            state_q <= DRAIN_REQ;
          end
        end
        DRAIN_REQ:  if (mem.gnt) state_q <= DRAIN_WAIT;
        DRAIN_WAIT: begin
          if (mem.rvalid) begin
            state_q <= IDLE;
            if (mem.error) drain_err_q <= 1'b1;
          end
        end
        READ_REQ:   if (mem.gnt) state_q <= READ_WAIT;
        READ_WAIT: begin
          if (mem.rvalid) begin
            rdata_q        <= mem.rdata;
            error_q        <= mem.error;
            rvalid_q       <= 1'b1;
            read_pending_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: directed scenarios followed by randomized
// traffic, checked against a flat memory image updated at write-accept time.
module tb_cache_write_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic empty_o, full_o, drain_error_o;

  cache_write_buffer_if up_bus();
  cache_write_buffer_if mem_bus();

  cache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .up(up_bus.slave), .mem(mem_bus.master),
    .empty_o(empty_o), .full_o(full_o), .drain_error_o(drain_error_o)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  // ---------------- memory responder (the real backing store) ----------------
  logic [31:0] memarr [1024];
  bit          memw   [1024];
  bit          gnt_en = 1'b0, gnt_rand = 1'b0, rand_gnt = 1'b0, err_inject = 1'b0;
  logic        resp_we;
  int          drained;
  txn_t        mem_log[$];
  txn_t        order_log[$];

  assign mem_bus.gnt = mem_bus.req & (rand_gnt ? gnt_rand : gnt_en);

  always @(posedge clk) gnt_rand <= ($urandom_range(0, 3) != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_bus.rvalid <= 1'b0;
      mem_bus.rdata  <= '0;
      mem_bus.error  <= 1'b0;
      resp_we        <= 1'b0;
      drained        <= 0;
    end else begin
      if (mem_bus.rvalid && resp_we) drained <= drained + 1;
      mem_bus.rvalid <= 1'b0;
      mem_bus.error  <= 1'b0;
      if (mem_bus.req && mem_bus.gnt) begin
        mem_log.push_back({mem_bus.we, mem_bus.addr, mem_bus.wdata, mem_bus.be});
        order_log.push_back({mem_bus.we, mem_bus.addr, mem_bus.wdata, mem_bus.be});
        mem_bus.rvalid <= 1'b1;
        mem_bus.error  <= err_inject;
        resp_we        <= mem_bus.we;
        if (mem_bus.we) begin
          memarr[mem_bus.addr[11:2]] <= merge(memw[mem_bus.addr[11:2]] ? memarr[mem_bus.addr[11:2]]
                                              : init_val({mem_bus.addr[31:2], 2'b00}),
                                              mem_bus.wdata, mem_bus.be);
          memw[mem_bus.addr[11:2]]   <= 1'b1;
          mem_bus.rdata <= '0;
        end else begin
          mem_bus.rdata <= memw[mem_bus.addr[11:2]] ? memarr[mem_bus.addr[11:2]]
                                                   : init_val({mem_bus.addr[31:2], 2'b00});
        end
      end
    end
  end

  // ---------------- reference model (sequentially consistent view) ----------------
  logic [31:0] refmem [1024];
  txn_t        exp_wq[$];
  int          acc, gcnt = 0, rv_cnt = 0;
  txn_t        mt, et;

  always @(posedge clk or posedge reset) begin
    if (reset) acc <= 0;
    else if (up_bus.req && up_bus.we && up_bus.gnt) acc <= acc + 1;
  end

  always @(posedge clk) if (up_bus.req && up_bus.gnt) gcnt <= gcnt + 1;

  // Occupancy flags, drained write contents and order, one response per grant
  always @(negedge clk) begin
    if (!reset) begin
      chk("mon_empty", empty_o, 32'(acc == drained));
      chk("mon_full", full_o, 32'((acc - drained) == DEPTH));
      if (up_bus.rvalid) rv_cnt++;
      if (mem_bus.req && !mem_bus.we) chk("mon_rd_be", mem_bus.be, 4'hF);
      while (mem_log.size() > 0) begin
        mt = mem_log.pop_front();
        if (mt.we) begin
          chk("mon_wr_expected", 32'(exp_wq.size() > 0), 1);
          if (exp_wq.size() > 0) begin
            et = exp_wq.pop_front();
            chk("mon_wr_addr", mt.addr, et.addr);
            chk("mon_wr_data", mt.data, et.data);
            chk("mon_wr_be", mt.be, et.be);
          end
        end
      end
    end
  end

  // ---------------- upstream driver ----------------
  task automatic start_req(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    up_bus.req = 1'b1; up_bus.we = we; up_bus.addr = a; up_bus.wdata = d; up_bus.be = be;
    #1;
  endtask

  task automatic wait_gnt(string tag, int budget, output bit ok);
    int n = 0;
    while (!up_bus.gnt && n < budget) begin @(negedge clk); #1; n++; end
    ok = up_bus.gnt;
    chk({tag, "_gnt"}, up_bus.gnt, 1);
  endtask

  // Called while gnt is high: update the model, complete the handshake, check the response
  task automatic finish_req(string tag, bit exp_err, output int lat);
    logic [31:0] exp_d;
    bit we = up_bus.we;
    if (we) begin
      refmem[up_bus.addr[11:2]] = merge(refmem[up_bus.addr[11:2]], up_bus.wdata, up_bus.be);
      exp_wq.push_back({1'b1, up_bus.addr, up_bus.wdata, up_bus.be});
      exp_d = '0;
    end else begin
      exp_d = refmem[up_bus.addr[11:2]];
    end
    @(posedge clk); #1;
    up_bus.req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!up_bus.rvalid && lat < 60) begin @(negedge clk); lat++; end
    chk({tag, "_rvalid"}, up_bus.rvalid, 1);
    chk({tag, "_rdata"}, up_bus.rdata, exp_d);
    chk({tag, "_err"}, up_bus.error, 32'(exp_err));
    if (we) chk({tag, "_wlat"}, lat, 1);
  endtask

  task automatic up_xact(string tag, bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                         bit exp_err, output int lat);
    bit ok;
    start_req(we, a, d, be);
    wait_gnt(tag, 300, ok);
    if (ok) finish_req(tag, exp_err, lat);
    else begin up_bus.req = 1'b0; lat = -1; end
  endtask

  task automatic wait_empty(string tag, int budget);
    int n = 0;
    while (!empty_o && n < budget) begin @(negedge clk); n++; end
    chk(tag, empty_o, 1);
  endtask

  task automatic hold_no_gnt(string tag, int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk(tag, up_bus.gnt, 0);
      @(negedge clk); #1;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, d0;
    bit ok;
    logic [31:0] a, d;
    for (int i = 0; i < 1024; i++) refmem[i] = init_val(32'(i) << 2);
    up_bus.req = 1'b0; up_bus.we = 1'b0; up_bus.addr = '0; up_bus.wdata = '0; up_bus.be = '0;

    // Reset values
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_drain_err", drain_error_o, 0);
    chk("rst_mem_req", mem_bus.req, 0);
    chk("rst_rvalid", up_bus.rvalid, 0);
    chk("rst_gnt", up_bus.gnt, 0);
    reset = 1'b0;
    @(negedge clk);

    // Three buffered writes with memory stalled, then drained in order
    gnt_en = 1'b0;
    up_xact("t1_w0", 1, 32'h100, 32'h1111_0000, 4'hF, 0, lat);
    up_xact("t1_w1", 1, 32'h104, 32'h2222_0000, 4'h3, 0, lat);
    up_xact("t1_w2", 1, 32'h108, 32'h3333_0000, 4'hC, 0, lat);
    chk("t1_not_empty", empty_o, 0);
    repeat (3) begin
      chk("t1_mem_req", mem_bus.req, 1);
      chk("t1_mem_we", mem_bus.we, 1);
      chk("t1_mem_addr", mem_bus.addr, 32'h100);
      chk("t1_mem_wdata", mem_bus.wdata, 32'h1111_0000);
      chk("t1_mem_be", mem_bus.be, 4'hF);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    wait_empty("t1_empty", 60);
    chk("t1_n", order_log.size(), 3);
    chk("t1_o0", order_log[0].addr, 32'h100);
    chk("t1_o1", order_log[1].addr, 32'h104);
    chk("t1_o2", order_log[2].addr, 32'h108);
    order_log.delete();

    // Fill to DEPTH; 5th write and a read both blocked until a pop
    gnt_en = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      up_xact("t2_fill", 1, 32'h140 + 32'(4 * i), $urandom, 4'hF, 0, lat);
    chk("t2_full", full_o, 1);
    start_req(1, 32'h150, 32'hCAFE_0150, 4'hF);
    hold_no_gnt("t2_w5_blocked", 3);
    start_req(0, 32'h700, 32'h0, 4'h0);
    hold_no_gnt("t2_rd_blocked", 2);
    d0 = drained;
    start_req(1, 32'h150, 32'hCAFE_0150, 4'hF);
    gnt_en = 1'b1;
    wait_gnt("t2_w5", 100, ok);
    chk("t2_pop_first", 32'((drained - d0) >= 1), 1);
    if (ok) finish_req("t2_w5", 0, lat);
    up_xact("t2_rd", 0, 32'h700, 32'h0, 4'h0, 0, lat);
    wait_empty("t2_empty", 80);
    order_log.delete();

    // Hazarding read waits for the matching drain, then sees the new data
    gnt_en = 1'b0;
    up_xact("t3_w", 1, 32'h200, 32'hDEAD_BEEF, 4'hF, 0, lat);
    d0 = drained;
    start_req(0, 32'h200, 32'h0, 4'h0);
    hold_no_gnt("t3_haz_blocked", 3);
    gnt_en = 1'b1;
    wait_gnt("t3_rd", 100, ok);
    chk("t3_drain_done", drained - d0, 1);
    if (ok) finish_req("t3_rd", 0, lat);
    chk("t3_rdata", up_bus.rdata, 32'hDEAD_BEEF);
    chk("t3_n", order_log.size(), 2);
    chk("t3_rd_we", order_log[1].we, 0);
    chk("t3_rd_addr", order_log[1].addr, 32'h200);
    order_log.delete();

    // Non-hazard read overtakes a buffered write; 3-cycle read latency
    gnt_en = 1'b1;
    up_xact("t4_w", 1, 32'h300, 32'h0300_0300, 4'hF, 0, lat);
    up_xact("t4_rd", 0, 32'h400, 32'h0, 4'h0, 0, lat);
    chk("t4_rlat", lat, 3);
    wait_empty("t4_empty", 40);
    chk("t4_first_we", order_log[0].we, 0);
    chk("t4_first_addr", order_log[0].addr, 32'h400);
    chk("t4_second_addr", order_log[1].addr, 32'h300);
    order_log.delete();

    // Sticky drain error; read error only on its own response
    err_inject = 1'b1;
    up_xact("t5_w", 1, 32'h500, 32'h5555_5555, 4'hF, 0, lat);
    wait_empty("t5_empty", 40);
    chk("t5_drain_err", drain_error_o, 1);
    up_xact("t5_rd_err", 0, 32'h504, 32'h0, 4'h0, 1, lat);
    err_inject = 1'b0;
    up_xact("t5_rd_ok", 0, 32'h508, 32'h0, 4'h0, 0, lat);
    chk("t5_drain_err_sticky", drain_error_o, 1);

    // Reset in DRAIN_REQ with two entries
    gnt_en = 1'b0;
    up_xact("t6_w0", 1, 32'h900, 32'h9999_0000, 4'hF, 0, lat);
    up_xact("t6_w1", 1, 32'h904, 32'h9999_0004, 4'hF, 0, lat);
    chk("t6_in_drain", mem_bus.req, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t6_mem_req_drop", mem_bus.req, 0);
    chk("t6_empty", empty_o, 1);
    chk("t6_drain_err_clr", drain_error_o, 0);
    exp_wq.delete(); order_log.delete();
    refmem[32'h900 >> 2] = init_val(32'h900);
    refmem[32'h904 >> 2] = init_val(32'h904);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    up_xact("t6_w_after", 1, 32'h908, 32'h0908_0908, 4'h5, 0, lat);
    gnt_en = 1'b1;
    wait_empty("t6_empty_after", 40);
    chk("t6_n", order_log.size(), 1);
    chk("t6_addr_after", order_log[0].addr, 32'h908);
    order_log.delete();

    // Randomized traffic over a small aliasing address pool
    rand_gnt = 1'b1;
    for (int n = 0; n < 150; n++) begin
      a = 32'h800 + 32'(4 * $urandom_range(0, 7));
      d = $urandom;
      up_xact("rnd", 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(1, 15)), 0, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_gnt = 1'b0;
    gnt_en = 1'b1;
    wait_empty("rnd_empty", 100);
    repeat (2) @(negedge clk);
    chk("rnd_wq_drained", exp_wq.size(), 0);
    chk("rvalid_per_gnt", rv_cnt, gcnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case something wedges the sequence
  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
